l2_home_stub: RTL

- Single-requestor home-node model for standalone L2 bring-up and verification.
- Sits at the LLC end of the L2 request/response channels. Accepts L2 requests (GETS/GETM/PUTS/PUTM) and returns data responses on the L2 response-in channel or put-acks on the L2 forward-in channel.
- Backed by a small directly indexed line store with per-entry coherence state. Runs after a fixed, configurable latency.

---
 rtl/l2_home_stub_if.sv | 44 ++++
 rtl/l2_home_stub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_home_stub_if.sv
// L2 <-> home-node channel bundle: request-out, response-in and forward-in.
// master = L2 cache side, slave = home node.
interface l2_home_stub_if #(
    parameter int unsigned LINE_ADDR_W = 28,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned INVACK_W    = 4,
    parameter int unsigned CACHE_ID_W  = 4
);
    logic                   l2_req_out_valid;
    logic                   l2_req_out_ready;
    logic [1:0]             l2_req_out_coh_msg;
    logic [1:0]             l2_req_out_hprot;
    logic [LINE_ADDR_W-1:0] l2_req_out_addr;
    logic [LINE_W-1:0]      l2_req_out_line;

    logic                   l2_rsp_in_valid;
    logic                   l2_rsp_in_ready;
    logic [1:0]             l2_rsp_in_coh_msg;
    logic [LINE_ADDR_W-1:0] l2_rsp_in_addr;
    logic [LINE_W-1:0]      l2_rsp_in_line;
    logic [INVACK_W-1:0]    l2_rsp_in_invack_cnt;

    logic                   l2_fwd_in_valid;
    logic                   l2_fwd_in_ready;
    logic [2:0]             l2_fwd_in_coh_msg;
    logic [LINE_ADDR_W-1:0] l2_fwd_in_addr;
    logic [CACHE_ID_W-1:0]  l2_fwd_in_req_id;

    modport master (
        output l2_req_out_valid, l2_req_out_coh_msg, l2_req_out_hprot, l2_req_out_addr,
               l2_req_out_line, l2_rsp_in_ready, l2_fwd_in_ready,
        input  l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in_coh_msg, l2_rsp_in_addr,
               l2_rsp_in_line, l2_rsp_in_invack_cnt, l2_fwd_in_valid, l2_fwd_in_coh_msg,
               l2_fwd_in_addr, l2_fwd_in_req_id
    );

    modport slave (
        input  l2_req_out_valid, l2_req_out_coh_msg, l2_req_out_hprot, l2_req_out_addr,
               l2_req_out_line, l2_rsp_in_ready, l2_fwd_in_ready,
        output l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in_coh_msg, l2_rsp_in_addr,
               l2_rsp_in_line, l2_rsp_in_invack_cnt, l2_fwd_in_valid, l2_fwd_in_coh_msg,
               l2_fwd_in_addr, l2_fwd_in_req_id
    );
endinterface

// File: rtl/l2_home_stub.sv
// Single-requestor home-node stub: directly indexed line store with I/S/E/M state,
// one transaction at a time, response after a fixed latency.
module l2_home_stub #(
    parameter int unsigned LINE_ADDR_W = 28,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned INVACK_W    = 4,
    parameter int unsigned CACHE_ID_W  = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned STUB_ID     = 0
) (
    input logic          clk,
    input logic          rst,
    l2_home_stub_if.slave bus
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] MsgGets = 2'd0;
    localparam logic [1:0] MsgGetm = 2'd1;
    localparam logic [1:0] MsgPutm = 2'd3;

    localparam logic [1:0] RspData  = 2'd0;
    localparam logic [1:0] RspEdata = 2'd1;
    localparam logic [2:0] FwdPutAck = 3'd3;

    localparam logic [1:0] CohI = 2'd0;
    localparam logic [1:0] CohS = 2'd1;
    localparam logic [1:0] CohE = 2'd2;
    localparam logic [1:0] CohM = 2'd3;

    typedef enum logic [1:0] {StIdle, StWait, StSendRsp, StSendFwd} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [1:0]             msg_q, msg_d;
    logic [1:0]             hprot_q, hprot_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]      line_q, line_d;

    logic                   ready_q, ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [1:0]             rsp_coh_q, rsp_coh_d;
    logic [LINE_ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [LINE_W-1:0]      rsp_line_q, rsp_line_d;
    logic                   fwd_valid_q, fwd_valid_d;
    logic [2:0]             fwd_coh_q, fwd_coh_d;
    logic [LINE_ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
    logic [CACHE_ID_W-1:0]  fwd_id_q, fwd_id_d;

    logic [LINE_W-1:0] line_mem [DEPTH];
    logic [1:0]        coh_mem  [DEPTH];
    logic [IdxW-1:0]   idx;
    logic [1:0]        cur_coh;
    logic              coh_we, line_we;
    logic [1:0]        coh_wdata;

    // No tag check: aliasing addresses deliberately share an entry.
    assign idx     = addr_q[IdxW-1:0];
    assign cur_coh = coh_mem[idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_d       = msg_q;
        hprot_d     = hprot_q;
        addr_d      = addr_q;
        line_d      = line_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_coh_d   = rsp_coh_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_line_d  = rsp_line_q;
        fwd_valid_d = fwd_valid_q;
        fwd_coh_d   = fwd_coh_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_id_d    = fwd_id_q;
        coh_we      = 1'b0;
        line_we     = 1'b0;
        coh_wdata   = CohI;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (bus.l2_req_out_valid && ready_q) begin
                    msg_d   = bus.l2_req_out_coh_msg;
                    hprot_d = bus.l2_req_out_hprot;
                    addr_d  = bus.l2_req_out_addr;
                    line_d  = bus.l2_req_out_line;
                    cnt_d   = CntW'(LATENCY - 1);
                    ready_d = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (!msg_q[1]) begin
                        rsp_valid_d = 1'b1;
                        rsp_addr_d  = addr_q;
                        rsp_line_d  = line_mem[idx];
                        rsp_coh_d   = (msg_q == MsgGets && cur_coh == CohI) ? RspEdata : RspData;
                        state_d     = StSendRsp;
                    end else begin
                        fwd_valid_d = 1'b1;
                        fwd_coh_d   = FwdPutAck;
                        fwd_addr_d  = addr_q;
                        fwd_id_d    = CACHE_ID_W'(STUB_ID);
                        state_d     = StSendFwd;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSendRsp: begin
                if (bus.l2_rsp_in_ready) begin
                    coh_we = 1'b1;
                    if (msg_q == MsgGetm) begin
                        coh_wdata = CohM;
                    end else begin
                        coh_wdata = (cur_coh == CohI) ? CohE : CohS;
                    end
                    rsp_valid_d = 1'b0;
                    rsp_coh_d   = '0;
                    rsp_addr_d  = '0;
                    rsp_line_d  = '0;
                    ready_d     = 1'b1;
                    state_d     = StIdle;
                end
            end
            StSendFwd: begin
                if (bus.l2_fwd_in_ready) begin
                    coh_we      = 1'b1;
                    coh_wdata   = CohI;
                    line_we     = (msg_q == MsgPutm);
                    fwd_valid_d = 1'b0;
                    fwd_coh_d   = '0;
                    fwd_addr_d  = '0;
                    fwd_id_d    = '0;
                    ready_d     = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            msg_q       <= '0;
            hprot_q     <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_coh_q   <= '0;
            rsp_addr_q  <= '0;
            rsp_line_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_coh_q   <= '0;
            fwd_addr_q  <= '0;
            fwd_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            msg_q       <= msg_d;
            hprot_q     <= hprot_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_coh_q   <= rsp_coh_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_line_q  <= rsp_line_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_coh_q   <= fwd_coh_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_id_q    <= fwd_id_d;
        end
    end

    // Store commits only on the response/forward handshake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                line_mem[i] <= '0;
                coh_mem[i]  <= CohI;
            end
        end else begin
            if (coh_we) begin
                coh_mem[idx] <= coh_wdata;
            end
            if (line_we) begin
                line_mem[idx] <= line_q;
            end
        end
    end

    assign bus.l2_req_out_ready     = ready_q;
    assign bus.l2_rsp_in_valid      = rsp_valid_q;
    assign bus.l2_rsp_in_coh_msg    = rsp_coh_q;
    assign bus.l2_rsp_in_addr       = rsp_addr_q;
    assign bus.l2_rsp_in_line       = rsp_line_q;
    assign bus.l2_rsp_in_invack_cnt = '0;
    assign bus.l2_fwd_in_valid      = fwd_valid_q;
    assign bus.l2_fwd_in_coh_msg    = fwd_coh_q;
    assign bus.l2_fwd_in_addr       = fwd_addr_q;
    assign bus.l2_fwd_in_req_id     = fwd_id_q;

endmodule
